// File: rtl/alu_ctrl_seq_if.sv
// Issue-side bundle for alu_ctrl_seq: decode fields in, decoded op / status out.
interface alu_ctrl_seq_if;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       out_valid;
   logic [4:0] alu_op;
   logic       illegal;
   logic       multicycle;
   logic       busy;

   modport master (
      output flush, in_valid, opcode, funct3, funct7,
      input  in_ready, out_valid, alu_op, illegal, multicycle, busy
   );

   modport slave (
      input  flush, in_valid, opcode, funct3, funct7,
      output in_ready, out_valid, alu_op, illegal, multicycle, busy
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered RV32I/M ALU-control decoder; 1 cycle for base ops, MUL_LAT/DIV_LAT for M ops.
// in_ready drops while an M op is in flight; flush aborts it with no output pulse.
module alu_ctrl_seq #(
   parameter bit ENABLE_M = 1'b1,
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 8
) (
   input  logic          clk,
   input  logic          reset,
   alu_ctrl_seq_if.slave bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00110;
   localparam logic [4:0] OP_LUI  = 5'b01000;
   localparam logic [4:0] OP_SRL  = 5'b01010;
   localparam logic [4:0] OP_SRA  = 5'b01011;
   localparam logic [4:0] OP_SLL  = 5'b01101;
   localparam logic [4:0] OP_SLT  = 5'b10110;
   localparam logic [4:0] OP_SLTU = 5'b10111;

   localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
   localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

   state_t     state, state_n;
   logic [5:0] cnt, cnt_n;
   logic       out_valid_q, out_valid_n;
   logic [4:0] alu_op_q, alu_op_n;
   logic       illegal_q, illegal_n;
   logic       multicycle_q, multicycle_n;
   logic [4:0] hold_op, hold_op_n;

   logic [4:0] base_op;
   logic [4:0] dec_op;
   logic       dec_ill;
   logic       dec_mc;
   logic [5:0] lat;

   // funct3 -> op shared by R-type and I-type when funct7 is all zero
   always_comb begin
      base_op = OP_ADD;
      case (bus.funct3)
         3'b000:  base_op = OP_ADD;
         3'b001:  base_op = OP_SLL;
         3'b010:  base_op = OP_SLT;
         3'b011:  base_op = OP_SLTU;
         3'b100:  base_op = OP_XOR;
         3'b101:  base_op = OP_SRL;
         3'b110:  base_op = OP_OR;
         default: base_op = OP_AND;
      endcase
   end

   always_comb begin
      dec_op  = OP_ADD;
      dec_ill = 1'b0;
      dec_mc  = 1'b0;
      case (bus.opcode)
         7'b0110011: begin
            if (bus.funct7 == 7'b0000000)
               dec_op = base_op;
            else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b000)
               dec_op = OP_SUB;
            else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b101)
               dec_op = OP_SRA;
            else if (ENABLE_M && bus.funct7 == 7'b0000001) begin
               dec_op = {2'b11, bus.funct3};
               dec_mc = 1'b1;
            end else
               dec_ill = 1'b1;
         end
         7'b0010011: begin
            if (bus.funct3 == 3'b001)
               dec_ill = (bus.funct7 != 7'b0000000);
            else if (bus.funct3 == 3'b101)
               dec_ill = (bus.funct7 != 7'b0000000) && (bus.funct7 != 7'b0100000);
            dec_op = (bus.funct3 == 3'b101 && bus.funct7[5]) ? OP_SRA : base_op;
         end
         7'b0000011: dec_ill = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
         7'b0100011: dec_ill = (bus.funct3 == 3'b011) || bus.funct3[2];
         7'b1100011: begin
            case (bus.funct3)
               3'b000:  dec_op = 5'b10000;
               3'b001:  dec_op = 5'b10001;
               3'b100:  dec_op = 5'b10010;
               3'b101:  dec_op = 5'b10011;
               3'b110:  dec_op = 5'b10100;
               3'b111:  dec_op = 5'b10101;
               default: dec_ill = 1'b1;
            endcase
         end
         7'b1101111: dec_op = OP_ADD;
         7'b1100111: dec_ill = (bus.funct3 != 3'b000);
         7'b0010111: dec_op = OP_ADD;
         7'b0110111: dec_op = OP_LUI;
         default:    dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_op = OP_ADD;
         dec_mc = 1'b0;
      end
   end

   assign lat = bus.funct3[2] ? DIV_CNT : MUL_CNT;

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      out_valid_n  = 1'b0;
      alu_op_n     = alu_op_q;
      illegal_n    = illegal_q;
      multicycle_n = multicycle_q;
      hold_op_n    = hold_op;
      if (bus.flush) begin
         state_n = IDLE;
         cnt_n   = 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (dec_mc && lat > 6'd1) begin
                     state_n   = BUSY;
                     cnt_n     = lat - 6'd1;
                     hold_op_n = dec_op;
                  end else begin
                     out_valid_n  = 1'b1;
                     alu_op_n     = dec_op;
                     illegal_n    = dec_ill;
                     multicycle_n = dec_mc;
                  end
               end
            end
            default: begin
               cnt_n = cnt - 6'd1;
               if (cnt == 6'd1) begin
                  state_n      = IDLE;
                  cnt_n        = 6'd0;
                  out_valid_n  = 1'b1;
                  alu_op_n     = hold_op;
                  illegal_n    = 1'b0;
                  multicycle_n = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 6'd0;
         out_valid_q  <= 1'b0;
         alu_op_q     <= OP_ADD;
         illegal_q    <= 1'b0;
         multicycle_q <= 1'b0;
         hold_op      <= OP_ADD;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         out_valid_q  <= out_valid_n;
         alu_op_q     <= alu_op_n;
         illegal_q    <= illegal_n;
         multicycle_q <= multicycle_n;
         hold_op      <= hold_op_n;
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.busy       = (state == BUSY);
   assign bus.out_valid  = out_valid_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.illegal    = illegal_q;
   assign bus.multicycle = multicycle_q;
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised successor to the combinational ALU-control decoder.
- Decodes opcode/funct3/funct7 into a 5-bit ALU operation code, with full RV32I coverage including branches and jumps.
- Adds optional RV32M decode (ENABLE_M). M-extension operations are sequenced over a configurable multi-cycle latency, with a valid/ready handshake towards the issue stage.
- Sits between the instruction decode stage and the ALU/mul-div datapath; its busy output stalls issue.

Parameters:
ENABLE_M, 1, 1 = decode RV32M (funct7=0000001); 0 = those encodings are illegal
MUL_LAT, 3, cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU (1..15)
DIV_LAT, 8, cycles from accept to out_valid for DIV/DIVU/REM/REMU (1..63)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of the in-flight or accepting operation
in_valid  in  1  instruction fields valid
in_ready  out  1  block can accept this cycle
opcode  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7  in  7  instruction[31:25]
out_valid  out  1  one-cycle pulse; alu_op/illegal/multicycle valid
alu_op  out  5  ALU operation code
illegal  out  1  unsupported encoding
multicycle  out  1  result comes from the mul/div unit
busy  out  1  high while a multi-cycle op is in flight

Behaviour:
- Reset (async): state=IDLE, counter=0, out_valid=0, alu_op=00000, illegal=0, multicycle=0, busy=0, in_ready=1.
- Operation codes:
  - ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00110, LUI 01000, SRL 01010, SRA 01011, SLL 01101, SLT 10110, SLTU 10111.
  - BEQ 10000, BNE 10001, BLT 10010, BGE 10011, BLTU 10100, BGEU 10101.
  - M ops: 11000 + funct3 (MUL 11000 … REMU 11111).
- Decode:
  - R-type 0110011: funct7 0000000 / 0100000 selects per funct3. SUB and SRA only with 0100000. Any other funct7 is illegal, except 0000001 when ENABLE_M=1.
  - I-type 0010011: ADDI, SLTI, SLTIU, XORI, ORI and ANDI ignore funct7. SLLI requires funct7=0000000. SRLI/SRAI require 0000000/0100000. Otherwise illegal.
  - Loads 0000011: funct3 in {000,001,010,100,101} gives ADD, else illegal.
  - Stores 0100011: funct3 in {000,001,010} gives ADD, else illegal.
  - Branches 1100011: funct3 010/011 are illegal, others map to branch codes.
  - JAL 1101111 gives ADD. JALR 1100111 gives ADD only with funct3=000. AUIPC gives ADD. LUI gives 01000.
  - Every other opcode is illegal.
- Illegal handling: out_valid=1, illegal=1, alu_op=00000, multicycle=0, single-cycle timing.
- Handshake: accept when in_valid && in_ready && !flush. in_ready = (state==IDLE).
- FSM IDLE:
  - Accepted single-cycle or illegal op: outputs registered at the accept edge, so out_valid is high the following cycle for exactly one cycle. FSM stays IDLE, giving back-to-back throughput of 1/cycle.
  - Accepted M op, LAT = MUL_LAT or DIV_LAT by funct3[2]:
    - LAT=1: treated exactly as single-cycle, with multicycle=1.
    - LAT>1: go BUSY, counter=LAT-1, busy=1, in_ready=0.
- FSM BUSY:
  - Counter decrements each cycle.
  - On the edge where counter==1: out_valid, alu_op, multicycle=1 registered, counter=0, FSM returns to IDLE with busy=0. out_valid is therefore high exactly LAT cycles after the accept edge.
  - The next instruction can be accepted in the cycle out_valid is high.
- Decoded op is held in an internal register while BUSY. Input fields are ignored while in_ready=0.
- flush:
  - Next edge: FSM goes IDLE, counter=0, busy=0, out_valid=0. No pending out_valid is produced.
  - A flush coinciding with in_valid drops the instruction.
  - A flush on the same edge BUSY would complete suppresses out_valid.
- alu_op, illegal and multicycle hold their last values when out_valid=0.
- Reset asserted mid-BUSY aborts immediately to reset values.
- Counter width: 6 bits, enough for DIV_LAT ≤ 63.

Test Plan:
- Reset then in_valid with opcode=0110011, funct3=000, funct7=0100000 → next cycle out_valid=1, alu_op=00001, illegal=0, busy=0.
- Back-to-back ADDI, SRAI (f7=0100000), LUI, BGEU on 4 consecutive cycles → out_valid high on 4 consecutive cycles with alu_op 00000, 01011, 01000, 10101.
- DIVU (0110011/101/0000001), DIV_LAT=8 → in_ready=0 and busy=1 for 7 cycles, out_valid 8 cycles after accept, alu_op=11101, multicycle=1; in_valid held during BUSY is not accepted.
- Illegal encodings: SLLI with f7=0100000, branch funct3=010, opcode 1111111, and M op with ENABLE_M=0 → out_valid=1, illegal=1, alu_op=00000 for each.
- MUL accepted, flush asserted 1 cycle later → no out_valid, in_ready=1 next cycle; a flush coinciding with in_valid produces no output.
- reset asserted mid-DIV (3rd busy cycle) → all outputs return to reset values asynchronously; next ADD after release decodes normally.
